// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Purpose:
//   Front end for the raw board keys (active-low, asynchronous, bouncing).
//   Each key goes through a 2-flop synchroniser and then its own debounce
//   counter. key_out carries the clean active-low levels. One-cycle strobes
//   mark each accepted press and each accepted release.
//
// Optional feature:
//   KEY_DEBOUNCE_LONG_PRESS_EN - when this macro is defined, every key gets a
//   long-press counter. key_long pulses once per press after the key has been
//   held for LONG_CYC cycles. When the macro is undefined, key_long is
//   constant 0. The port list is the same in both builds.
//
// Parameters:
//   N_KEYS        number of keys
//   DEBOUNCE_CYC  stable cycles needed before a change is accepted
//   LONG_CYC      held-low cycles that count as a long press (macro build only)
//
// Ports:
//   clk          in   1       system clock
//   rst          in   1       synchronous, active-high reset
//   key_in       in   N_KEYS  raw keys, 0 = pressed, asynchronous
//   key_out      out  N_KEYS  debounced level, 0 = pressed
//   key_press    out  N_KEYS  1-cycle pulse when key_out goes 1->0
//   key_release  out  N_KEYS  1-cycle pulse when key_out goes 0->1
//   key_long     out  N_KEYS  1-cycle long-press pulse
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 240000,
    parameter int LONG_CYC     = 12000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    // The counter only ever has to hold values up to DEBOUNCE_CYC-1,
    // because it clears on the commit.
    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [N_KEYS-1:0] r_stable;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [CW-1:0]     r_cnt      [N_KEYS];
    logic [CW-1:0]     w_cnt_next [N_KEYS];
    logic [N_KEYS-1:0] w_diff;
    logic [N_KEYS-1:0] w_commit;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_deb
            assign w_diff[gi]   = r_s2[gi] ^ r_stable[gi];
            assign w_commit[gi] = w_diff[gi] && (r_cnt[gi] == CNT_LAST);
            // Any cycle where the synchronised input agrees with the
            // accepted level restarts the count. This is what rejects bounce.
            assign w_cnt_next[gi] = (!w_diff[gi] || w_commit[gi]) ? '0
                                                                   : r_cnt[gi] + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_stable  <= '1;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= key_in;
            r_s2      <= r_s1;
            r_stable  <= r_stable ^ w_commit;
            // The strobes are registered next to r_stable, so each pulse
            // lines up with the cycle in which key_out changes.
            r_press   <= w_commit & r_stable;
            r_release <= w_commit & ~r_stable;
            for (int i = 0; i < N_KEYS; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign key_out     = r_stable;
    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_CYC);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

    logic [LW-1:0]     r_long_cnt      [N_KEYS];
    logic [LW-1:0]     w_long_cnt_next [N_KEYS];
    logic [N_KEYS-1:0] r_long_fired;
    logic [N_KEYS-1:0] r_long;
    logic [N_KEYS-1:0] w_long_hit;
    logic [N_KEYS-1:0] w_fired_next;

    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_long
            // The pulse is registered on the edge where the count reaches
            // LONG_CYC. It appears exactly LONG_CYC cycles after key_press.
            assign w_long_hit[gi] = !r_stable[gi] && !r_long_fired[gi] &&
                                    (r_long_cnt[gi] == LONG_LAST);
            // The count holds at LONG_TOP, so it cannot come back round to
            // fire a second pulse during the same press.
            assign w_long_cnt_next[gi] = r_stable[gi] ? '0 :
                                         (r_long_cnt[gi] == LONG_TOP) ? r_long_cnt[gi]
                                                                      : r_long_cnt[gi] + 1'b1;
            assign w_fired_next[gi] = r_release[gi] ? 1'b0
                                                    : (r_long_fired[gi] | w_long_hit[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_long_fired <= '0;
            r_long       <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_long_cnt[i] <= '0;
            end
        end else begin
            r_long_fired <= w_fired_next;
            r_long       <= w_long_hit;
            for (int i = 0; i < N_KEYS; i++) begin
                r_long_cnt[i] <= w_long_cnt_next[i];
            end
        end
    end

    assign key_long = r_long;
`else
    // No long-press logic is built. The AND with (LONG_CYC > 0) only keeps
    // the parameter referenced. The result is still constant zero.
    assign key_long = {N_KEYS{1'b0}} & {N_KEYS{LONG_CYC > 0}};
`endif

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Directed bench for key_debounce, with DEBOUNCE_CYC=8 and LONG_CYC=32.
// Most of the behaviour comes from a table of per-cycle vectors. Each vector
// holds the inputs driven before a rising edge and the outputs expected just
// after that edge. Hand-written loops cover the bounce, mid-debounce reset
// and long-press sequences.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DC = 8;
    localparam int LC = 32;
    localparam int LAT = DC + 2;  // edges from key_in change to key_out change

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_out;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    int n_cmp;
    int n_fail;

    key_debounce #(
        .N_KEYS      (NK),
        .DEBOUNCE_CYC(DC),
        .LONG_CYC    (LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic [3:0] out;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    vec_t tbl[$];

    task automatic add_n(input int n, input logic r, input logic [3:0] k,
                         input logic [3:0] o, input logic [3:0] p, input logic [3:0] rl);
        vec_t v;
        v.rst = r; v.key = k; v.out = o; v.press = p; v.rel = rl;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive the inputs, advance one edge, then sample 1 ns after the edge.
    task automatic step(input logic r, input logic [3:0] k);
        rst = r;
        key_in = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] o, input logic [3:0] p,
                         input logic [3:0] rl, input logic [3:0] lg);
        logic [15:0] act;
        logic [15:0] exp;
        act = {key_out, key_press, key_release, key_long};
        exp = {o, p, rl, lg};
        n_cmp++;
        if (act !== exp || (key_press & key_release) !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s @%0t: out/press/rel/long got %h, want %h", name, $time, act, exp);
        end
    endtask

    logic       long_en;
    logic [3:0] exp_o;
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    logic [3:0] exp_l;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        long_en = 1'b1;
`else
        long_en = 1'b0;
`endif
        rst    = 1'b1;
        key_in = 4'b1111;

        // Reset state.
        add_n(3, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        // Key 0 press: key_out changes on edge 10, with a single press pulse.
        add_n(LAT-1, 1'b0, 4'b1110, 4'b1111, 4'b0000, 4'b0000);
        add_n(1,     1'b0, 4'b1110, 4'b1110, 4'b0001, 4'b0000);
        add_n(2,     1'b0, 4'b1110, 4'b1110, 4'b0000, 4'b0000);
        // Key 0 release.
        add_n(LAT-1, 1'b0, 4'b1111, 4'b1110, 4'b0000, 4'b0000);
        add_n(1,     1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
        add_n(2,     1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        // All four keys together: press, then release.
        add_n(LAT-1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        add_n(1,     1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        add_n(2,     1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add_n(LAT-1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add_n(1,     1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
        add_n(2,     1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].key);
            check($sformatf("vec%0d", i), tbl[i].out, tbl[i].press, tbl[i].rel, 4'b0000);
        end

        // Bounce on key 1: the key toggles every 3 cycles, so it is never
        // stable for DEBOUNCE_CYC cycles and key_out must not change.
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (((c / 3) % 2) != 0) ? 4'b1101 : 4'b1111);
            check("bounce", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        end
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'b1111);
            check("bounce_idle", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        end

        // Key 2 held, with reset pulsed part-way through the debounce.
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b1011);
            check("pre_rst", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        end
        step(1'b1, 4'b1011);
        check("mid_rst", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1'b0, 4'b1011);
            exp_o = (c >= LAT) ? 4'b1011 : 4'b1111;
            exp_p = (c == LAT) ? 4'b0100 : 4'b0000;
            check("post_rst", exp_o, exp_p, 4'b0000, 4'b0000);
        end
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1'b0, 4'b1111);
            exp_o = (c >= LAT) ? 4'b1111 : 4'b1011;
            exp_r = (c == LAT) ? 4'b0100 : 4'b0000;
            check("rel2", exp_o, 4'b0000, exp_r, 4'b0000);
        end

        // Key 3 held for 60 cycles. With long-press enabled, exactly one
        // pulse is expected LONG_CYC edges after the press pulse.
        for (int c = 1; c <= 60; c++) begin
            step(1'b0, 4'b0111);
            exp_o = (c >= LAT) ? 4'b0111 : 4'b1111;
            exp_p = (c == LAT) ? 4'b1000 : 4'b0000;
            exp_l = (long_en && c == LAT + LC) ? 4'b1000 : 4'b0000;
            check("long", exp_o, exp_p, 4'b0000, exp_l);
        end
        for (int c = 1; c <= LAT + 2; c++) begin
            step(1'b0, 4'b1111);
            exp_o = (c >= LAT) ? 4'b1111 : 4'b0111;
            exp_r = (c == LAT) ? 4'b1000 : 4'b0000;
            check("rel3", exp_o, 4'b0000, exp_r, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
